// File: rtl/fractal_pkg.sv
// fractal_pkg: shared Q-format constants, state types and helpers
// for the fractal lane engine (fractal_lane, fractal_lane_engine).
package fractal_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 28;

    // 4.0 in product format: 2*FRAC_W fraction bits, 2*DATA_W+1 wide
    localparam logic [2*DEF_DATA_W:0] ESCAPE_R2 =
        (2*DEF_DATA_W+1)'(1) << (2*DEF_FRAC_W + 2);

    typedef enum logic [1:0] {
        L_IDLE,
        L_ITER,
        L_HOLD
    } lane_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } scan_state_t;

    // bit position of 4.0 in the product format for any FRAC_W
    function automatic int escape_shift(input int frac_w);
        return 2*frac_w + 2;
    endfunction

    // (a + b) mod n for 0 <= a,b < n
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/fractal_lane.sv
// fractal_lane: one iteration lane, z = z^2 + c until escape or cap.
// Holds its result until the output arbiter grants it.
module fractal_lane
    import fractal_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int ITER_W  = 24,
    parameter int COORD_W = 10
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               i_load,
    input  logic               i_grant,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [DATA_W-1:0]  i_c_re,
    input  logic [DATA_W-1:0]  i_c_im,
    input  logic [DATA_W-1:0]  i_z0_re,
    input  logic [DATA_W-1:0]  i_z0_im,
    input  logic [ITER_W-1:0]  i_max_iter,
    output logic               o_idle,
    output logic               o_hold,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [ITER_W-1:0]  o_iter
);

    localparam int PW = 2*DATA_W + 1;
    localparam logic [PW-1:0] ESC = PW'(1) << escape_shift(FRAC_W);

    lane_state_t r_state;
    lane_state_t w_state_nxt;

    logic [DATA_W-1:0]  r_zr, r_zi, r_cr, r_ci;
    logic [ITER_W-1:0]  r_cnt;
    logic [COORD_W-1:0] r_x, r_y;

    logic signed [2*DATA_W-1:0] w_zr_w, w_zi_w;
    logic signed [2*DATA_W-1:0] w_rr, w_ii, w_ri;
    logic        [PW-1:0]       w_mag;
    logic signed [PW-1:0]       w_diff;
    logic [DATA_W-1:0]          w_zr_nxt, w_zi_nxt;
    logic                       w_stop;

    assign w_zr_w = {{DATA_W{r_zr[DATA_W-1]}}, r_zr};
    assign w_zi_w = {{DATA_W{r_zi[DATA_W-1]}}, r_zi};
    assign w_rr   = w_zr_w * w_zr_w;
    assign w_ii   = w_zi_w * w_zi_w;
    assign w_ri   = w_zr_w * w_zi_w;

    // escape test on the full-width sum, never wraps
    assign w_mag  = {1'b0, w_rr} + {1'b0, w_ii};
    assign w_diff = {w_rr[2*DATA_W-1], w_rr} - {w_ii[2*DATA_W-1], w_ii};
    assign w_stop = (w_mag > ESC) || (r_cnt == i_max_iter);

    // z update truncates products back to the Q format
    assign w_zr_nxt = DATA_W'(w_diff >>> FRAC_W) + r_cr;
    assign w_zi_nxt = DATA_W'((w_ri <<< 1) >>> FRAC_W) + r_ci;

    // lane state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= L_IDLE;
        else        r_state <= w_state_nxt;
    end

    // lane next-state: load, iterate until stop, wait for grant
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            L_IDLE:  if (i_load)  w_state_nxt = L_ITER;
            L_ITER:  if (w_stop)  w_state_nxt = L_HOLD;
            L_HOLD:  if (i_grant) w_state_nxt = L_IDLE;
            default: w_state_nxt = L_IDLE;
        endcase
    end

    // lane datapath: capture pixel on load, step z while iterating
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_zr  <= '0;
            r_zi  <= '0;
            r_cr  <= '0;
            r_ci  <= '0;
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (r_state == L_IDLE && i_load) begin
            r_zr  <= i_z0_re;
            r_zi  <= i_z0_im;
            r_cr  <= i_c_re;
            r_ci  <= i_c_im;
            r_cnt <= '0;
            r_x   <= i_x;
            r_y   <= i_y;
        end else if (r_state == L_ITER && !w_stop) begin
            r_zr  <= w_zr_nxt;
            r_zi  <= w_zi_nxt;
            r_cnt <= r_cnt + ITER_W'(1);
        end
    end

    assign o_idle = (r_state == L_IDLE);
    assign o_hold = (r_state == L_HOLD);
    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_iter = r_cnt;

endmodule

// File: rtl/fractal_lane_engine.sv
// fractal_lane_engine: raster scan, dispatch to idle lanes, RR output.
// Define JULIA_MODE_EN to add the julia_* ports and Julia iteration.
module fractal_lane_engine
    import fractal_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_W    = DEF_FRAC_W,
    parameter int ITER_W    = 24,
    parameter int COORD_W   = 10
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               start,
    input  logic [COORD_W-1:0] x_dim,
    input  logic [COORD_W-1:0] y_dim,
    input  logic [DATA_W-1:0]  re_lower,
    input  logic [DATA_W-1:0]  im_upper,
    input  logic [DATA_W-1:0]  step,
    input  logic [ITER_W-1:0]  max_iter,
`ifdef JULIA_MODE_EN
    input  logic               julia_sel,
    input  logic [DATA_W-1:0]  julia_re,
    input  logic [DATA_W-1:0]  julia_im,
`endif
    output logic               busy,
    output logic               done_frame,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [ITER_W-1:0]  out_iter
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    scan_state_t r_state, w_state_nxt;

    logic [COORD_W-1:0] r_xdim, r_ydim, r_x, r_y;
    logic [DATA_W-1:0]  r_re_lo, r_step, r_cre, r_cim;
    logic [ITER_W-1:0]  r_max;
    logic [DATA_W-1:0]  w_c_re, w_c_im, w_z0_re, w_z0_im;

    logic [NUM_LANES-1:0] w_idle, w_hold, w_load, w_grant;
    logic [COORD_W-1:0]   w_lx [NUM_LANES];
    logic [COORD_W-1:0]   w_ly [NUM_LANES];
    logic [ITER_W-1:0]    w_li [NUM_LANES];

    logic          w_any_idle, w_disp, w_last, w_take, w_gnt_any;
    logic [LW-1:0] w_gnt_idx, r_rr_ptr;

    logic               r_out_valid;
    logic [COORD_W-1:0] r_out_x, r_out_y;
    logic [ITER_W-1:0]  r_out_iter;

`ifdef JULIA_MODE_EN
    logic              r_jsel;
    logic [DATA_W-1:0] r_jre, r_jim;

    // Julia: pixel seeds z, constant is c; otherwise Mandelbrot
    always_comb begin
        w_c_re  = r_cre;
        w_c_im  = r_cim;
        w_z0_re = '0;
        w_z0_im = '0;
        if (r_jsel) begin
            w_c_re  = r_jre;
            w_c_im  = r_jim;
            w_z0_re = r_cre;
            w_z0_im = r_cim;
        end
    end
`else
    assign w_c_re  = r_cre;
    assign w_c_im  = r_cim;
    assign w_z0_re = '0;
    assign w_z0_im = '0;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fractal_lane #(
            .DATA_W  (DATA_W),
            .FRAC_W  (FRAC_W),
            .ITER_W  (ITER_W),
            .COORD_W (COORD_W)
        ) u_lane (
            .aclk       (aclk),
            .areset     (areset),
            .i_load     (w_load[g]),
            .i_grant    (w_grant[g]),
            .i_x        (r_x),
            .i_y        (r_y),
            .i_c_re     (w_c_re),
            .i_c_im     (w_c_im),
            .i_z0_re    (w_z0_re),
            .i_z0_im    (w_z0_im),
            .i_max_iter (r_max),
            .o_idle     (w_idle[g]),
            .o_hold     (w_hold[g]),
            .o_x        (w_lx[g]),
            .o_y        (w_ly[g]),
            .o_iter     (w_li[g])
        );
    end

    // dispatch current pixel to the lowest-indexed idle lane
    always_comb begin
        w_load     = '0;
        w_any_idle = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_idle[i]) begin
                w_load     = '0;
                w_load[i]  = 1'b1;
                w_any_idle = 1'b1;
            end
        end
        if (r_state != S_SCAN) w_load = '0;
    end

    assign w_disp = (r_state == S_SCAN) && w_any_idle;
    assign w_last = (r_x == r_xdim - COORD_W'(1)) &&
                    (r_y == r_ydim - COORD_W'(1));
    assign w_take = !r_out_valid || out_ready;

    // round-robin pick among holding lanes, from r_rr_ptr upward
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_grant   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!w_gnt_any &&
                w_hold[wrap_add(int'(r_rr_ptr), k, NUM_LANES)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = LW'(wrap_add(int'(r_rr_ptr), k, NUM_LANES));
            end
        end
        if (!w_take)   w_gnt_any = 1'b0;
        if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
    end

    // output register: refill from granted lane, hold until accepted
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_iter  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_gnt_any) begin
            r_out_valid <= 1'b1;
            r_out_x     <= w_lx[w_gnt_idx];
            r_out_y     <= w_ly[w_gnt_idx];
            r_out_iter  <= w_li[w_gnt_idx];
            r_rr_ptr    <= LW'(wrap_add(int'(w_gnt_idx), 1, NUM_LANES));
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // scan state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // scan next-state: empty frames skip straight to DONE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (x_dim == '0 || y_dim == '0) w_state_nxt = S_DONE;
                    else                            w_state_nxt = S_SCAN;
                end
            end
            S_SCAN:  if (w_disp && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (&w_idle && !r_out_valid) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // config latch and incremental pixel coordinates
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_xdim  <= '0;
            r_ydim  <= '0;
            r_re_lo <= '0;
            r_step  <= '0;
            r_max   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_cre   <= '0;
            r_cim   <= '0;
`ifdef JULIA_MODE_EN
            r_jsel  <= 1'b0;
            r_jre   <= '0;
            r_jim   <= '0;
`endif
        end else if (r_state == S_IDLE && start) begin
            r_xdim  <= x_dim;
            r_ydim  <= y_dim;
            r_re_lo <= re_lower;
            r_step  <= step;
            r_max   <= max_iter;
            r_x     <= '0;
            r_y     <= '0;
            r_cre   <= re_lower;
            r_cim   <= im_upper;
`ifdef JULIA_MODE_EN
            r_jsel  <= julia_sel;
            r_jre   <= julia_re;
            r_jim   <= julia_im;
`endif
        end else if (w_disp) begin
            if (r_x == r_xdim - COORD_W'(1)) begin
                r_x   <= '0;
                r_cre <= r_re_lo;
                r_y   <= r_y + COORD_W'(1);
                r_cim <= r_cim - r_step;
            end else begin
                r_x   <= r_x + COORD_W'(1);
                r_cre <= r_cre + r_step;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done_frame = (r_state == S_DONE);
    assign out_valid  = r_out_valid;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_iter   = r_out_iter;

endmodule

// File: tb/tb_fractal_lane_engine.sv
// tb_fractal_lane_engine: random frames against an escape-time model.
// Julia case is exercised when JULIA_MODE_EN is defined.
`timescale 1ns/1ps
module tb_fractal_lane_engine;

    localparam int NL  = 4;
    localparam int DW  = 32;
    localparam int FW  = 28;
    localparam int IW  = 24;
    localparam int CW  = 10;
    localparam int ONE = 32'h1000_0000;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] x_dim = '0, y_dim = '0;
    logic [DW-1:0] re_lower = '0, im_upper = '0, step = '0;
    logic [IW-1:0] max_iter = '0;
    logic          julia_sel = 1'b0;
    logic [DW-1:0] julia_re = '0, julia_im = '0;
    logic          busy, done_frame, out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_x, out_y;
    logic [IW-1:0] out_iter;

    int n_tests = 0;
    int n_fail  = 0;
    int got_cnt = 0;
    int done_cnt = 0;
    int last_iter = 0;
    int frame_xd = 0, frame_yd = 0;
    int ready_mode = 0;
    int exp_iter [256];
    bit exp_live [256];

    logic          pv = 1'b0;
    logic [CW-1:0] px, py;
    logic [IW-1:0] pit;
    int            kx, ky, key;

    always #5 aclk = ~aclk;

    fractal_lane_engine #(
        .NUM_LANES (NL), .DATA_W (DW), .FRAC_W (FW),
        .ITER_W (IW), .COORD_W (CW)
    ) dut (
        .aclk (aclk), .areset (areset), .start (start),
        .x_dim (x_dim), .y_dim (y_dim),
        .re_lower (re_lower), .im_upper (im_upper),
        .step (step), .max_iter (max_iter),
`ifdef JULIA_MODE_EN
        .julia_sel (julia_sel), .julia_re (julia_re),
        .julia_im (julia_im),
`endif
        .busy (busy), .done_frame (done_frame),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_x (out_x), .out_y (out_y), .out_iter (out_iter)
    );

    task automatic check_eq(input string name, input longint act,
                            input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic signed [71:0] sx(input int v);
        return {{40{v[31]}}, v};
    endfunction

    // escape-time count from the iteration rule, in wide arithmetic
    function automatic int model_iter(input int cr, input int ci,
                                      input int zr0, input int zi0,
                                      input int mi);
        logic signed [71:0] zr, zi, prr, pii, pri, lim;
        int nr, ni;
        lim = 72'sd1 <<< 58;
        zr = sx(zr0);
        zi = sx(zi0);
        for (int n = 0; n < mi; n++) begin
            prr = zr * zr;
            pii = zi * zi;
            pri = zr * zi;
            if (prr + pii > lim) return n;
            nr = int'((prr - pii) >>> 28) + cr;
            ni = int'((pri <<< 1) >>> 28) + ci;
            zr = sx(nr);
            zi = sx(ni);
        end
        return mi;
    endfunction

    // consumer ready pattern: 0 always, 1 random, 2 stalled
    always @(posedge aclk) begin
        #1;
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                      out_ready = 1'b0;
    end

    // compare process: stability, scoreboard, done pulses
    always @(negedge aclk) begin
        if (areset) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_x", out_x, px);
                check_eq("hold_y", out_y, py);
                check_eq("hold_iter", out_iter, pit);
            end
            if (done_frame) done_cnt++;
            if (out_valid && out_ready) begin
                kx = int'(out_x);
                ky = int'(out_y);
                n_tests++;
                if (kx >= frame_xd || ky >= frame_yd) begin
                    n_fail++;
                    $display("FAIL xy_range: got (%0d,%0d), frame %0dx%0d",
                             kx, ky, frame_xd, frame_yd);
                end else begin
                    key = ky * frame_xd + kx;
                    if (!exp_live[key]) begin
                        n_fail++;
                        $display("FAIL xy_unique: got (%0d,%0d) again",
                                 kx, ky);
                    end else begin
                        exp_live[key] = 1'b0;
                        check_eq("iter", out_iter, exp_iter[key]);
                    end
                end
                got_cnt++;
                last_iter = int'(out_iter);
                pv = 1'b0;
            end else begin
                pv = out_valid;
            end
            px = out_x;
            py = out_y;
            pit = out_iter;
        end
    end

    task automatic setup_expect(input int xd, input int yd, input int rl,
                                input int iu, input int st, input int mi,
                                input int js, input int jr, input int ji);
        int cre, cim;
        frame_xd = xd;
        frame_yd = yd;
        for (int i = 0; i < 256; i++) exp_live[i] = 1'b0;
        for (int y = 0; y < yd; y++) begin
            for (int x = 0; x < xd; x++) begin
                cre = rl + x * st;
                cim = iu - y * st;
                if (js != 0) exp_iter[y*xd+x] = model_iter(jr, ji, cre, cim, mi);
                else         exp_iter[y*xd+x] = model_iter(cre, cim, 0, 0, mi);
                exp_live[y*xd+x] = 1'b1;
            end
        end
        got_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input int xd, input int yd, input int rl,
                               input int iu, input int st, input int mi,
                               input int js, input int jr, input int ji);
        @(posedge aclk);
        #1;
        x_dim = CW'(xd);
        y_dim = CW'(yd);
        re_lower = rl;
        im_upper = iu;
        step = st;
        max_iter = IW'(mi);
        julia_sel = (js != 0);
        julia_re = jr;
        julia_im = ji;
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int xd, input int yd, input int rl,
                             input int iu, input int st, input int mi,
                             input int js, input int jr, input int ji,
                             input int hold);
        int waited;
        int budget;
        budget = xd * yd * (mi + 6) + 300;
        setup_expect(xd, yd, rl, iu, st, mi, js, jr, ji);
        if (hold > 0) ready_mode = 2;
        pulse_start(xd, yd, rl, iu, st, mi, js, jr, ji);
        if (hold > 0) begin
            repeat (hold) @(posedge aclk);
            #1;
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_busy", busy, 1);
            check_eq("stall_none_taken", got_cnt, 0);
            ready_mode = 1;
        end
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            @(posedge aclk);
            waited++;
        end
        check_eq("frame_done_in_time", done_cnt != 0, 1);
        repeat (3) @(posedge aclk);
        #1;
        check_eq("done_once", done_cnt, 1);
        check_eq("result_count", got_cnt, xd * yd);
        check_eq("idle_after", busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int xd, yd, rl, iu, st, mi;

        check_eq("model_c0", model_iter(0, 0, 0, 0, 16), 16);
        check_eq("model_c1", model_iter(ONE, 0, 0, 0, 100), 3);
        check_eq("model_c2", model_iter(2*ONE, 0, 0, 0, 100), 2);
        check_eq("model_julia", model_iter(0, 0, ONE + ONE/2, 0, 100), 1);
        check_eq("model_cap0", model_iter(3*ONE, 0, 0, 0, 0), 0);

        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done_frame, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_x", out_x, 0);
        check_eq("rst_y", out_y, 0);
        check_eq("rst_iter", out_iter, 0);

        run_frame(1, 1, 0, 0, ONE, 16, 0, 0, 0, 0);
        check_eq("lit_origin", last_iter, 16);
        run_frame(1, 1, ONE, 0, ONE, 100, 0, 0, 0, 0);
        check_eq("lit_c1", last_iter, 3);

        run_frame(4, 1, -2*ONE, 0, ONE/2, 50, 0, 0, 0, 100);

        ready_mode = 1;
        run_frame(8, 8, -2*ONE, ONE, ONE/2, 0, 0, 0, 0, 0);
        run_frame(0, 3, 0, 0, ONE, 10, 0, 0, 0, 0);
        run_frame(3, 0, 0, 0, ONE, 10, 0, 0, 0, 0);

        for (int f = 0; f < 6; f++) begin
            xd = $urandom_range(1, 6);
            yd = $urandom_range(1, 6);
            rl = int'($urandom_range(0, 20)) * (ONE/8) - 2*ONE;
            iu = int'($urandom_range(0, 16)) * (ONE/8) - ONE;
            st = ($urandom_range(0, 1) != 0) ? ONE/4 : ONE/8;
            mi = $urandom_range(0, 40);
            ready_mode = $urandom_range(0, 1);
            run_frame(xd, yd, rl, iu, st, mi, 0, 0, 0, 0);
        end

`ifdef JULIA_MODE_EN
        ready_mode = 0;
        run_frame(1, 1, ONE + ONE/2, 0, ONE, 100, 1, 0, 0, 0);
        check_eq("lit_julia", last_iter, 1);
`endif

        ready_mode = 1;
        setup_expect(8, 8, -2*ONE, 2*ONE, ONE/2, 200, 0, 0, 0);
        pulse_start(8, 8, -2*ONE, 2*ONE, ONE/2, 200, 0, 0, 0);
        repeat (30) @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done_frame, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        done_cnt = 0;
        repeat (5) @(posedge aclk);
        #1;
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_idle", busy, 0);

        run_frame(2, 2, -ONE, ONE/2, ONE/2, 30, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
